// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM burst arbiter types and geometry
package sdram_pkg;
  localparam int ADDR_W = 22;
  localparam int OFF_W = ADDR_W - 1;
  localparam int BURST_LEN = 256;
  localparam int FRAME_WORDS = 480000;
  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_BUSY, S_RD_REQ, S_RD_BUSY} state_t;
endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// sdram_burst_arbiter_if: burst request/handshake bus between arbiter and SDRAM controller
interface sdram_burst_arbiter_if
  import sdram_pkg::*;
;
  logic sdram_wr_req;
  logic sdram_rd_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic sdram_ack;
  logic sdram_done;
  modport master (output sdram_wr_req, sdram_rd_req, sdram_addr, input sdram_ack, sdram_done);
  modport slave (input sdram_wr_req, sdram_rd_req, sdram_addr, output sdram_ack, sdram_done);
endinterface

// File: rtl/sdram_frame_addr_gen.sv
// sdram_frame_addr_gen: per-direction burst offset counter with frame wrap and deferred frame reset
module sdram_frame_addr_gen
  import sdram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_step,
  input  logic i_frame_rst,
  input  logic i_busy,
  output logic [OFF_W-1:0] o_offset,
  output logic o_frame_end
);
  logic [OFF_W-1:0] r_offset;
  logic r_pend;
  logic w_wrap;
  assign w_wrap = r_offset == OFF_W'(FRAME_WORDS - BURST_LEN);
  // a reset seen mid-burst waits for done and replaces the increment; wrap and reset collapse into one frame end
  assign o_frame_end = i_step ? (i_frame_rst | r_pend | w_wrap) : (i_frame_rst & ~i_busy);
  assign o_offset = r_offset;
  // offset advance / frame restart and pending-reset latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset <= '0;
      r_pend <= 1'b0;
    end else begin
      r_offset <= o_frame_end ? '0 : i_step ? r_offset + OFF_W'(BURST_LEN) : r_offset;
      r_pend <= ~i_step & (r_pend | (i_frame_rst & i_busy));
    end
  end
endmodule

// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter: schedules camera-write and VGA-read SDRAM bursts over ping-pong frame banks
module sdram_burst_arbiter
  import sdram_pkg::*;
#(
  parameter int LEVEL_W = 11,
  parameter int RD_LOW = 256,
  parameter int RD_HIGH = 768,
  parameter int WR_OVF = 896
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_init_done,
  input  logic [LEVEL_W-1:0] i_wr_level,
  input  logic [LEVEL_W-1:0] i_rd_level,
  input  logic i_wr_frame_rst,
  input  logic i_rd_frame_rst,
  sdram_burst_arbiter_if.master bus,
  output logic o_vga_start,
  output logic o_wr_ovf_flag
);
  localparam logic [LEVEL_W-1:0] L_BURST = LEVEL_W'(BURST_LEN);
  localparam logic [LEVEL_W-1:0] L_RD_LOW = LEVEL_W'(RD_LOW);
  localparam logic [LEVEL_W-1:0] L_RD_MAX = LEVEL_W'(RD_HIGH - BURST_LEN);
  localparam logic [LEVEL_W-1:0] L_RD_HIGH = LEVEL_W'(RD_HIGH);
  localparam logic [LEVEL_W-1:0] L_WR_OVF = LEVEL_W'(WR_OVF);
  state_t r_state, w_next;
  logic r_last_rd, r_wr_bank, r_rd_bank, r_last_full, r_vga_start, r_wr_ovf;
  logic w_rd_ok, w_rd_urgent, w_wr_ok;
  logic w_wr_fe, w_rd_fe, w_rd_dir;
  logic [OFF_W-1:0] w_wr_off, w_rd_off;
  assign w_rd_ok = i_rd_level <= L_RD_MAX;
  assign w_rd_urgent = w_rd_ok && i_rd_level < L_RD_LOW;
  assign w_wr_ok = i_wr_level >= L_BURST;
  assign w_rd_dir = r_state == S_RD_REQ || r_state == S_RD_BUSY;
  sdram_frame_addr_gen u_wr_gen (
    .clk(clk), .rst_n(rst_n),
    .i_step(r_state == S_WR_BUSY && bus.sdram_done),
    .i_frame_rst(i_wr_frame_rst),
    .i_busy(r_state == S_WR_REQ || r_state == S_WR_BUSY),
    .o_offset(w_wr_off), .o_frame_end(w_wr_fe)
  );
  sdram_frame_addr_gen u_rd_gen (
    .clk(clk), .rst_n(rst_n),
    .i_step(r_state == S_RD_BUSY && bus.sdram_done),
    .i_frame_rst(i_rd_frame_rst),
    .i_busy(w_rd_dir),
    .o_offset(w_rd_off), .o_frame_end(w_rd_fe)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // next state: urgent read, then write/read with alternation on contention
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_init_done) w_next = w_rd_urgent ? S_RD_REQ : (w_wr_ok && w_rd_ok) ? (r_last_rd ? S_WR_REQ : S_RD_REQ) : w_wr_ok ? S_WR_REQ : w_rd_ok ? S_RD_REQ : S_IDLE;
      S_WR_REQ: if (bus.sdram_ack) w_next = S_WR_BUSY;
      S_WR_BUSY: if (bus.sdram_done) w_next = S_IDLE;
      S_RD_REQ: if (bus.sdram_ack) w_next = S_RD_BUSY;
      S_RD_BUSY: if (bus.sdram_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // outputs: requests straight from the state register, address from the active direction
  always_comb begin
    bus.sdram_wr_req = r_state == S_WR_REQ;
    bus.sdram_rd_req = r_state == S_RD_REQ;
    bus.sdram_addr = w_rd_dir ? {r_rd_bank, w_rd_off} : {r_wr_bank, w_wr_off};
  end
  // last grant direction; reset value makes the first contended grant a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last_rd <= 1'b1;
    else if (r_state == S_IDLE && w_next != S_IDLE) r_last_rd <= w_next == S_RD_REQ;
  end
  // ping-pong banks: reader follows the last completed write frame unless that is the bank now being written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b1;
      r_last_full <= 1'b0;
    end else begin
      if (w_wr_fe) begin
        r_wr_bank <= ~r_wr_bank;
        r_last_full <= r_wr_bank;
      end
      if (w_rd_fe) r_rd_bank <= (w_wr_fe ? r_wr_bank : r_last_full) == (w_wr_fe ? ~r_wr_bank : r_wr_bank) ? r_rd_bank : (w_wr_fe ? r_wr_bank : r_last_full);
    end
  end
  // sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vga_start <= 1'b0;
      r_wr_ovf <= 1'b0;
    end else begin
      r_vga_start <= r_vga_start | (i_rd_level >= L_RD_HIGH);
      r_wr_ovf <= r_wr_ovf | (i_wr_level >= L_WR_OVF);
    end
  end
  assign o_vga_start = r_vga_start;
  assign o_wr_ovf_flag = r_wr_ovf;
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb_sdram_burst_arbiter: randomized scoreboard bench against a frame/bank reference model
module tb_sdram_burst_arbiter;
  localparam int BL = 256;
  localparam int FW = 480000;
  typedef struct packed {logic rd; logic [21:0] addr;} exp_t;
  logic clk = 0, rst_n = 0, i_init_done = 0, i_wr_frame_rst = 0, i_rd_frame_rst = 0;
  logic [10:0] i_wr_level = 0, i_rd_level = 0;
  logic o_vga_start, o_wr_ovf_flag;
  int n_checks = 0, n_errors = 0;
  exp_t exp_q[$];
  int m_wr_off, m_rd_off;
  bit m_wr_bank, m_rd_bank, m_last_full, m_last_rd;
  bit mon_prev;
  logic [21:0] mon_addr;
  exp_t mon_e;
  sdram_burst_arbiter_if bus ();
  sdram_burst_arbiter dut (
    .clk(clk), .rst_n(rst_n), .i_init_done(i_init_done),
    .i_wr_level(i_wr_level), .i_rd_level(i_rd_level),
    .i_wr_frame_rst(i_wr_frame_rst), .i_rd_frame_rst(i_rd_frame_rst),
    .bus(bus), .o_vga_start(o_vga_start), .o_wr_ovf_flag(o_wr_ovf_flag)
  );
  always #5 clk = ~clk;
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic void model_reset();
    m_wr_off = 0; m_rd_off = 0; m_wr_bank = 0; m_rd_bank = 1; m_last_full = 0; m_last_rd = 1;
  endfunction
  function automatic void wr_fe();
    m_wr_off = 0;
    m_last_full = m_wr_bank;
    m_wr_bank = !m_wr_bank;
  endfunction
  function automatic void rd_fe();
    m_rd_off = 0;
    if (m_last_full != m_wr_bank) m_rd_bank = m_last_full;
  endfunction
  function automatic void advance(input bit rd);
    if (rd) begin
      m_rd_off += BL;
      if (m_rd_off == FW) rd_fe();
    end else begin
      m_wr_off += BL;
      if (m_wr_off == FW) wr_fe();
    end
  endfunction
  function automatic logic [21:0] addr_of(input bit bank, input int off);
    return {bank, 21'(off)};
  endfunction
  function automatic bit pred_rd(input int wl, input int rl);
    bit rok = rl <= 768 - BL;
    bit wok = wl >= BL;
    if (rok && rl < 256) return 1;
    if (wok && rok) return !m_last_rd;
    return !wok;
  endfunction
  task automatic set_rst(input bit rd, input logic v);
    if (rd) i_rd_frame_rst = v;
    else i_wr_frame_rst = v;
  endtask
  task automatic quiet();
    i_wr_level = 11'd0;
    i_rd_level = 11'd900;
  endtask
  // mode: 0 none, 1 same-dir frame rst in REQ, 2 in BUSY, 3 together with done
  task automatic burst(input int wl, input int rl, input int ack_d, input int done_d, input int mode, input bit other, input bit drop);
    exp_t e;
    bit rd, got;
    rd = pred_rd(wl, rl);
    m_last_rd = rd;
    e.rd = rd;
    e.addr = rd ? addr_of(m_rd_bank, m_rd_off) : addr_of(m_wr_bank, m_wr_off);
    exp_q.push_back(e);
    i_wr_level = 11'(wl);
    i_rd_level = 11'(rl);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = bus.sdram_wr_req | bus.sdram_rd_req;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: got no request expected rd=%0d", rd);
      exp_q.delete();
      quiet();
      cyc();
      return;
    end
    cyc();
    if (drop) i_init_done = 0;
    if (mode == 1) begin set_rst(rd, 1); cyc(); set_rst(rd, 0); end
    repeat (ack_d) cyc();
    chk("req_held", 32'(rd ? bus.sdram_rd_req : bus.sdram_wr_req), 1);
    chk("other_req_low", 32'(rd ? bus.sdram_wr_req : bus.sdram_rd_req), 0);
    bus.sdram_ack = 1;
    cyc();
    bus.sdram_ack = 0;
    if (mode == 2) begin set_rst(rd, 1); cyc(); set_rst(rd, 0); end
    if (other) begin
      set_rst(!rd, 1);
      cyc();
      set_rst(!rd, 0);
      if (rd) wr_fe();
      else rd_fe();
    end
    repeat (done_d) cyc();
    bus.sdram_done = 1;
    if (mode == 3) set_rst(rd, 1);
    cyc();
    bus.sdram_done = 0;
    set_rst(rd, 0);
    if (mode != 0) begin
      if (rd) rd_fe();
      else wr_fe();
    end else advance(rd);
    if (drop) begin
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        chk("no_req_init_low", 32'(bus.sdram_wr_req | bus.sdram_rd_req), 0);
      end
      #1;
      i_init_done = 1;
    end
    quiet();
  endtask
  // monitor: pops expected grants on each new request and checks address stability while held
  always @(negedge clk) begin
    if (!rst_n) mon_prev = 0;
    else begin
      if (bus.sdram_wr_req && bus.sdram_rd_req) chk("both_req", 1, 0);
      if ((bus.sdram_wr_req | bus.sdram_rd_req) && !mon_prev) begin
        if (exp_q.size() == 0) chk("unexpected_req", 32'(bus.sdram_addr), 32'hffff_ffff);
        else begin
          mon_e = exp_q.pop_front();
          chk("grant_dir", 32'(bus.sdram_rd_req), 32'(mon_e.rd));
          chk("grant_addr", 32'(bus.sdram_addr), 32'(mon_e.addr));
        end
        mon_addr = bus.sdram_addr;
      end else if (bus.sdram_wr_req | bus.sdram_rd_req) chk("addr_stable", 32'(bus.sdram_addr), 32'(mon_addr));
      mon_prev = bus.sdram_wr_req | bus.sdram_rd_req;
    end
  end
  initial begin
    bus.sdram_ack = 0;
    bus.sdram_done = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_wr_req", 32'(bus.sdram_wr_req), 0);
    chk("rst_rd_req", 32'(bus.sdram_rd_req), 0);
    chk("rst_addr", 32'(bus.sdram_addr), 0);
    chk("rst_vga_start", 32'(o_vga_start), 0);
    chk("rst_wr_ovf", 32'(o_wr_ovf_flag), 0);
    cyc();
    rst_n = 1;
    i_wr_level = 11'd895;
    i_rd_level = 11'd767;
    repeat (3) cyc();
    @(negedge clk);
    chk("vga_start_below", 32'(o_vga_start), 0);
    chk("wr_ovf_below", 32'(o_wr_ovf_flag), 0);
    chk("no_req_before_init", 32'(bus.sdram_wr_req | bus.sdram_rd_req), 0);
    cyc();
    i_wr_level = 11'd896;
    i_rd_level = 11'd768;
    repeat (2) cyc();
    @(negedge clk);
    chk("vga_start_set", 32'(o_vga_start), 1);
    chk("wr_ovf_set", 32'(o_wr_ovf_flag), 1);
    cyc();
    i_wr_level = 11'd0;
    i_rd_level = 11'd0;
    repeat (4) cyc();
    @(negedge clk);
    chk("vga_start_sticky", 32'(o_vga_start), 1);
    chk("wr_ovf_sticky", 32'(o_wr_ovf_flag), 1);
    cyc();
    rst_n = 0;
    @(negedge clk);
    chk("vga_start_cleared", 32'(o_vga_start), 0);
    chk("wr_ovf_cleared", 32'(o_wr_ovf_flag), 0);
    cyc();
    quiet();
    rst_n = 1;
    model_reset();
    i_init_done = 1;
    cyc();
    burst(300, 900, 0, 0, 0, 0, 0);
    burst(600, 100, 0, 0, 0, 0, 0);
    repeat (4) burst(400, 400, 1, 1, 0, 0, 0);
    burst(300, 900, 0, 2, 2, 0, 0);
    burst(300, 900, 0, 0, 0, 0, 0);
    burst(300, 900, 100, 0, 0, 0, 0);
    burst(300, 900, 1, 1, 0, 0, 1);
    repeat (1875) burst(300, 900, 0, 0, 0, 0, 0);
    set_rst(1, 1);
    cyc();
    set_rst(1, 0);
    rd_fe();
    burst(0, 400, 0, 0, 0, 0, 0);
    bus.sdram_done = 1;
    cyc();
    bus.sdram_done = 0;
    bus.sdram_ack = 1;
    cyc();
    bus.sdram_ack = 0;
    burst(300, 400, 0, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      int wl, rl, md;
      do begin
        wl = $urandom_range(0, 1000);
        rl = $urandom_range(0, 1000);
      end while (wl < BL && rl > 768 - BL);
      md = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if ($urandom_range(0, 5) == 0) begin
        set_rst($urandom_range(0, 1) == 1, 1);
        cyc();
        if (i_rd_frame_rst) rd_fe();
        else wr_fe();
        set_rst(0, 0);
        set_rst(1, 0);
      end
      burst(wl, rl, $urandom_range(0, 3), $urandom_range(0, 4), md, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
    end
    repeat (5) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
